// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder slice.
// Holds the FSM state encoding, the bus widths, the wait counter width and
// a helper that turns a word count into an array index width.
package mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // A single-word array still needs a one-bit index.
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store requester and the data memory
// responder.
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_addr            : 16-bit word address
//   req_wdata           : 32-bit store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data, 0 for stores and errors
//   rsp_err             : address was outside the array
// Modports: master is the requester, slave is the responder.
interface data_mem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_array.sv
// Word storage for the responder: synchronous write, synchronous read.
//   clk   : clock
//   we    : write enable, writes wdata to addr on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : word at addr as it stood before this edge (read-before-write)
// The array has no reset so its contents survive a responder reset.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // One read port and one write port sharing the same index; the read
    // returns the old word when both happen on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES edges, performs the array access, then presents a response
// until the requester takes it.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-low
//   bus   : request/response bus (slave side)
// Parameters: DEPTH words in the array, WAIT_CYCLES access wait states (1..15).
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int                IDX_W     = index_width(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              req_ready_c;
    logic              rsp_valid_c;
    logic              accept;
    logic              access_edge;
    logic              in_range;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_addr;
    logic [DATA_W-1:0] arr_rdata;

    assign accept      = req_ready_c & bus.req_valid;
    assign access_edge = (state == ACCESS) && (cnt == CNT_LAST);
    // The range check looks at all 16 address bits, while only the low
    // index bits reach the array.
    assign in_range    = ({1'b0, addr_q} < DEPTH_LIM);
    assign arr_we      = access_edge & we_q & in_range;
    // While idle the array reads the incoming address so that, even with a
    // single wait state, the read data for the latched address is already
    // registered when the access edge arrives.
    assign arr_addr    = (state == IDLE) ? bus.req_addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    data_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // State register; reset drops any in-flight transaction back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs. Ready is only offered in IDLE, so a
    // request can never be taken on the same edge as a response handshake.
    always_comb begin
        next_state  = state;
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == CNT_LAST) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latch, wait counter and response register. The request fields
    // are captured only on the accept edge; the response is written only on
    // the access edge and then holds until the next access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= WAIT_LOAD;
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end else if (state == ACCESS) begin
            cnt <= cnt - 1'b1;
            if (access_edge) begin
                rdata_q <= (!we_q && in_range) ? arr_rdata : '0;
                err_q   <= ~in_range;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (DEPTH=1024, WAIT_CYCLES=2).
// Requests are issued by a driver that pushes the expected response into a
// queue at the accept edge; an independent monitor pops and compares each
// response when it is handshaken. The reference memory is an associative
// array updated by plain load/store rules.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int WAIT  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    data_mem_responder_if bus();

    data_mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int               total = 0;
    int               bad   = 0;
    logic [32:0]      exp_q [$];
    logic [31:0]      model [int];
    bit               hold_ready = 1'b0;
    logic [15:0]      addr_set [12] = '{16'h0000, 16'h0001, 16'h0002, 16'h0005,
                                        16'h0010, 16'h0020, 16'h0100, 16'h03FF,
                                        16'h0400, 16'h0401, 16'h8010, 16'hFFFF};

    // Free-running clock.
    always #5 clk = ~clk;

    // Global time limit so the run can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Expected {err, rdata} from the memory rules, using the model state
    // before this request takes effect.
    function automatic logic [32:0] expect_of(input logic we, input logic [15:0] addr);
        logic err;
        logic [31:0] rd;
        err = (int'(addr) >= DEPTH);
        rd  = 32'h0;
        if (!we && !err && model.exists(int'(addr))) begin
            rd = model[int'(addr)];
        end
        return {err, rd};
    endfunction

    // Issue one request, record its expectation at the accept edge, scramble
    // the request fields afterwards and check latency and busy ready.
    task automatic apply_stimulus(input logic we, input logic [15:0] addr,
                                  input logic [31:0] wd, output int waited);
        int k;
        waited        = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        while (!bus.req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got no ready want ready");
            bus.req_valid = 1'b0;
            return;
        end
        exp_q.push_back(expect_of(we, addr));
        if (we && int'(addr) < DEPTH) begin
            model[int'(addr)] = wd;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = $urandom;
        k = 0;
        while (!bus.rsp_valid && k < 100) begin
            check_output("busy_ready", 32'(bus.req_ready), 32'h0);
            @(posedge clk);
            #1;
            k++;
        end
        check_output("latency", 32'(k), 32'(WAIT));
    endtask

    // Requester's response acceptance: random back-pressure unless held off.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every handshaken response with the queue head and
    // checks that a stalled response holds its data.
    initial begin
        logic        held;
        logic [32:0] hv;
        logic [32:0] e;
        held = 1'b0;
        hv   = '0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (held) begin
                    check_output("hold_rdata", bus.rsp_rdata, hv[31:0]);
                    check_output("hold_err", 32'(bus.rsp_err), 32'(hv[32]));
                end
                if (bus.rsp_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_rsp: got 0x%08h want none", bus.rsp_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("rsp_rdata", bus.rsp_rdata, e[31:0]);
                        check_output("rsp_err", 32'(bus.rsp_err), 32'(e[32]));
                    end
                end else begin
                    held = 1'b1;
                    hv   = {bus.rsp_err, bus.rsp_rdata};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Main sequence: reset, directed cases, then randomized traffic.
    initial begin
        int w;
        int n;
        logic [31:0] r0;
        logic        e0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) @(negedge clk);
        check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_output("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_output("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
        check_output("reset_req_ready", 32'(bus.req_ready), 32'h1);
        reset = 1'b1;

        apply_stimulus(1'b1, 16'h0010, 32'hDEADBEEF, w);
        check_output("first_accept", 32'(w), 32'h0);
        apply_stimulus(1'b0, 16'h0010, 32'h0, w);

        foreach (addr_set[i]) begin
            if (int'(addr_set[i]) < DEPTH && addr_set[i] != 16'h0010) begin
                apply_stimulus(1'b1, addr_set[i], $urandom, w);
            end
        end

        apply_stimulus(1'b1, 16'h0400, 32'h12345678, w);
        apply_stimulus(1'b0, 16'h0000, 32'h0, w);
        apply_stimulus(1'b0, 16'h8010, 32'h0, w);

        // Stalled response with a competing request pending.
        hold_ready = 1'b1;
        apply_stimulus(1'b0, 16'h0020, 32'h0, w);
        r0 = bus.rsp_rdata;
        e0 = bus.rsp_err;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_output("stall_valid", 32'(bus.rsp_valid), 32'h1);
            check_output("stall_rdata", bus.rsp_rdata, r0);
            check_output("stall_err", 32'(bus.rsp_err), 32'(e0));
            check_output("stall_no_accept", 32'(bus.req_ready), 32'h0);
        end
        bus.req_valid = 1'b0;
        hold_ready    = 1'b0;

        // Reset one cycle after accepting a store: it must never land.
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0020;
        bus.req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check_output("abort_req_ready", 32'(bus.req_ready), 32'h1);
        check_output("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_output("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_output("abort_rsp_err", 32'(bus.rsp_err), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b0, 16'h0020, 32'h0, w);
        check_output("release_accept", 32'(w), 32'h0);

        repeat (150) begin
            apply_stimulus(1'($urandom_range(0, 1)), addr_set[$urandom_range(0, 11)], $urandom, w);
        end

        n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words held.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning access wait states; legal range is 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the requester presents a load/store.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 The block SHALL have port req_addr, input, 16 bits: word address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: the requester takes the response.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: load data; 0 for stores and errors.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: the address was out of range (req_addr >= DEPTH).

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, ACCESS and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-016 In IDLE, when req_valid and req_ready are both 1 at a rising edge, the block SHALL latch req_we, req_addr and req_wdata, load the wait counter with WAIT_CYCLES, and enter ACCESS.
REQ-017 Request inputs SHALL be ignored at every edge other than the accept edge.
REQ-018 In ACCESS, the counter SHALL decrement by one each edge; on the edge where the counter equals 1, the array access SHALL be performed and the FSM SHALL enter RESP.
REQ-019 Latency SHALL be as follows: with an accept edge at T, rsp_valid is 1 after edge T+WAIT_CYCLES.
REQ-020 A store SHALL write the latched data on the access edge only; its response SHALL carry rsp_rdata=0.
REQ-021 A load SHALL capture the array word at the latched address on the access edge into the response register.
REQ-022 For an out-of-range address, the block SHALL drop a store, return rsp_rdata=0 for a load, and set rsp_err=1; in-range accesses SHALL return rsp_err=0.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL remain stable until rsp_ready=1 at an edge; on that edge the FSM SHALL enter IDLE.
REQ-024 A new request SHALL NOT be accepted in the same edge as the response handshake; minimum spacing between accepts is WAIT_CYCLES+2 cycles.
REQ-025 A load issued after a store to the same address SHALL return the stored data.
REQ-026 Only the low ceil(log2(DEPTH)) address bits SHALL index the array; the range check SHALL use all 16 bits.

Reset
REQ-027 Asserting reset (low) SHALL immediately force IDLE, the counter to 0, rsp_valid=0, rsp_rdata=0 and rsp_err=0, and req_ready to 1 once reset is released.
REQ-028 Reset during ACCESS SHALL abort the transaction, and a store whose access edge has not yet occurred SHALL NOT be written.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 After reset is released, the first accept SHALL be possible at the first rising edge.

Structure
REQ-031 The shared package mem_pkg SHALL hold the FSM state encoding, the address width (16), the data width (32) and the counter width (4).
REQ-032 The storage SHALL be one sub-module, data_mem_array, a synchronous-write, synchronous-read word array with ports clk, we, addr, wdata and rdata.
REQ-033 The FSM, wait counter, range check and response register SHALL reside in data_mem_responder.

Verification
REQ-034 Store 0xDEADBEEF at address 0x0010, then load 0x0010 -> load response rsp_rdata=0xDEADBEEF, rsp_err=0; store response rsp_rdata=0.
REQ-035 With WAIT_CYCLES=2, a load accepted at edge 5 -> rsp_valid first 1 after edge 7; req_ready=0 after edges 5 through 7.
REQ-036 Hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err unchanged for the whole hold, and no new accept while req_valid=1.
REQ-037 Store 0x12345678 to address 0x0400 with DEPTH=1024 -> rsp_err=1; a following load from 0x0000 is unchanged from its prior value.
REQ-038 Assert reset one cycle after accepting a store of 0xA5A5A5A5 to 0x0020 -> state is IDLE; a later load of 0x0020 returns the prior contents, not 0xA5A5A5A5.
REQ-039 Change req_addr and req_wdata during ACCESS -> the response reflects only the values latched at accept.
